mem_port_arbiter: RTL and testbench

Arbitrates the single-port unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage RISC-V pipeline. Each granted access is a latched, multi-cycle transaction. The block raises per-port stall signals that the pipeline controller uses to gate `pc_wen`, `if_id_wen` and the later stage enables. Data accesses have priority, and a starvation guard ensures fetches still make progress.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, data port, memory port and the
// status outputs of mem_port_arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives the rest)
//   master : environment view (pipeline requesters plus the memory)
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // data port
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  // memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // status
  logic        stall_if;
  logic        stall_mem;
  logic        err_timeout;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err_timeout
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a single-port unified memory between the IF
// fetch port and the MEM load/store port. Each grant is a latched multi-cycle
// transaction ending in a one-cycle ack. Data accesses win, but after DM_BURST
// consecutive data grants with a fetch pending, the fetch is served.
// Ports:
//   clk  - CPU clock
//   rstn - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (fetch, data, memory ports, stalls, err_timeout)
// Parameters:
//   MAX_WAIT - cycles a transaction waits for mem_ready before it is aborted
//   DM_BURST - max consecutive data grants while a fetch is pending
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned DM_BURST = 4
) (
  input  logic               clk,
  input  logic               rstn,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned BW = $clog2(DM_BURST + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(DM_BURST);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   dm_rdata_q;
  logic          if_ack_q;
  logic          dm_ack_q;
  logic          err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      wait_cnt    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.if_req) burst_cnt <= '0;
          if (bus.dm_req && (!bus.if_req || burst_cnt < BURST_MAX)) begin
            // only contended data grants count towards the burst limit
            if (bus.if_req) burst_cnt <= burst_cnt + 1'b1;
            state       <= BUSY_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            wait_cnt    <= '0;
          end else if (bus.if_req) begin
            burst_cnt   <= '0;
            state       <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            wait_cnt    <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          // the ack is raised on the same edge that enters DONE, so it is
          // visible for exactly the DONE cycle
          if (bus.mem_ready || wait_cnt == WAIT_MAX) begin
            mem_req_q <= 1'b0;
            state     <= DONE;
            if (!bus.mem_ready) err_q <= 1'b1;
            if (state == BUSY_IF) begin
              if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
              if_ack_q   <= 1'b1;
            end else begin
              dm_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
              dm_ack_q   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.err_timeout = err_q;
  assign bus.stall_if    = bus.if_req & ~if_ack_q;
  assign bus.stall_mem   = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned DM_BURST = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .DM_BURST(DM_BURST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // memory model: ready after mem_lat wait cycles, read data derived from address
  int mem_lat   = 0;
  bit mem_never = 1'b0;
  int mem_cnt   = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
  endfunction

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (!mem_never && mem_cnt >= mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd_val(bus.mem_addr);
        end else begin
          mem_cnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        mem_cnt = 0;
      end
    end
  end

  // grant log: one record per mem_req transaction, held stable until completion
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t grant_q[$];
  grant_t cur_g;
  logic   prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (prev_req !== 1'b1) begin
          cur_g = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
          grant_q.push_back(cur_g);
        end else begin
          check1 ("mem_we_stable",    bus.mem_we,    cur_g.we);
          check32("mem_addr_stable",  bus.mem_addr,  cur_g.addr);
          check32("mem_wdata_stable", bus.mem_wdata, cur_g.wdata);
        end
      end
      prev_req = bus.mem_req;
    end
  end

  // scoreboard: expected read data per port, popped on each ack
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  int   if_acks = 0;
  int   dm_acks = 0;
  logic prev_if_ack = 1'b0;
  logic prev_dm_ack = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.if_ack === 1'b1) begin
        if_acks++;
        check1("if_ack_single_cycle", prev_if_ack, 1'b0);
        check1("if_ack_expected", if_q.size() > 0, 1'b1);
        if (if_q.size() > 0) check32("if_rdata", bus.if_rdata, if_q.pop_front());
      end
      if (bus.dm_ack === 1'b1) begin
        dm_acks++;
        check1("dm_ack_single_cycle", prev_dm_ack, 1'b0);
        check1("dm_ack_expected", dm_q.size() > 0, 1'b1);
        if (dm_q.size() > 0) check32("dm_rdata", bus.dm_rdata, dm_q.pop_front());
      end
      prev_if_ack = bus.if_ack;
      prev_dm_ack = bus.dm_ack;
    end
  end

  // One transaction on one port. Called at a negedge; returns at the negedge
  // of the ack cycle. exp_lat < 0 means the port may lose arbitration, so no
  // latency check and no input scrambling. hold keeps req high for a
  // back-to-back follow-up call.
  task automatic do_req(input bit is_dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input bit hold,
                        input logic [31:0] exp_rdata);
    int cyc;
    bit got;
    if (is_dm) begin
      dm_q.push_back(exp_rdata);
      bus.dm_we    = we;
      bus.dm_addr  = addr;
      bus.dm_wdata = wdata;
      bus.dm_req   = 1'b1;
    end else begin
      if_q.push_back(exp_rdata);
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      got = is_dm ? bus.dm_ack : bus.if_ack;
      if (is_dm) check1("stall_mem", bus.stall_mem, !got);
      else       check1("stall_if",  bus.stall_if,  !got);
      if (cyc == 1 && exp_lat >= 0) begin
        bus.if_addr  = $urandom();
        bus.dm_addr  = $urandom();
        bus.dm_wdata = $urandom();
        bus.dm_we    = ~we;
      end
    end
    check1(is_dm ? "dm_ack_seen" : "if_ack_seen", got, 1'b1);
    if (exp_lat >= 0) checkn(is_dm ? "dm_latency" : "if_latency", cyc, exp_lat);
    if (!hold || !got) begin
      if (is_dm) bus.dm_req = 1'b0;
      else       bus.if_req = 1'b0;
    end
  endtask

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t   vecs[5];
  grant_t g;
  int     a0;
  bit     got;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         0, 32'h0000_0013, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1234, 32'h1111_2222, 1, 32'h1234_EDCB, 1'b0, 32'h1111_2222};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0100_FEFF, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         3, 32'h0040_FFBF, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'hFFFC_0003, 1'b0, 32'h0};

    rstn         = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = 32'hCAFE_F00D;

    repeat (3) @(negedge clk);
    check1 ("rst_mem_req",  bus.mem_req,     1'b0);
    check1 ("rst_mem_we",   bus.mem_we,      1'b0);
    check32("rst_mem_addr", bus.mem_addr,    32'h0);
    check1 ("rst_if_ack",   bus.if_ack,      1'b0);
    check1 ("rst_dm_ack",   bus.dm_ack,      1'b0);
    check1 ("rst_err",      bus.err_timeout, 1'b0);
    check32("rst_if_rdata", bus.if_rdata,    32'h0);
    check32("rst_dm_rdata", bus.dm_rdata,    32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven single transactions
    for (int i = 0; i < 5; i++) begin
      grant_q.delete();
      mem_lat = vecs[i].lat;
      bus.dm_wdata = 32'hCAFE_F00D;
      do_req(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             2 + vecs[i].lat, 1'b0, vecs[i].exp_rdata);
      checkn("vec_grants", grant_q.size(), 1);
      if (grant_q.size() > 0) begin
        g = grant_q.pop_front();
        check1 ("vec_mem_we",    g.we,    vecs[i].exp_we);
        check32("vec_mem_addr",  g.addr,  vecs[i].addr);
        check32("vec_mem_wdata", g.wdata, vecs[i].exp_wdata);
      end
      check1("vec_err_clear", bus.err_timeout, 1'b0);
      @(negedge clk);
    end

    // simultaneous requests: store wins, fetch follows
    grant_q.delete();
    mem_lat = 0;
    fork
      do_req(1'b0, 1'b0, 32'h0000_0200, 32'h0,         -1, 1'b0, 32'h0200_FDFF);
      do_req(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, -1, 1'b0, 32'h0100_FEFF);
    join
    repeat (2) @(negedge clk);
    checkn("both_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check1 ("both_first_we",     grant_q[0].we,    1'b1);
      check32("both_first_addr",   grant_q[0].addr,  32'h0000_0100);
      check32("both_first_wdata",  grant_q[0].wdata, 32'hDEAD_BEEF);
      check1 ("both_second_we",    grant_q[1].we,    1'b0);
      check32("both_second_addr",  grant_q[1].addr,  32'h0000_0200);
      check32("both_second_wdata", grant_q[1].wdata, 32'h0);
    end

    // burst limit: dm_req held through 6 accesses, one fetch pending
    grant_q.delete();
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 6; k++)
          do_req(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0, -1, 1'b1, rd_val(32'h300 + 32'(4 * k)));
        bus.dm_req = 1'b0;
      end
      do_req(1'b0, 1'b0, 32'h0000_0080, 32'h0, -1, 1'b0, 32'h0080_FF7F);
    join
    repeat (2) @(negedge clk);
    checkn("burst_grants", grant_q.size(), 7);
    if (grant_q.size() == 7) begin
      check32("burst_addr0", grant_q[0].addr, 32'h300);
      check32("burst_addr1", grant_q[1].addr, 32'h304);
      check32("burst_addr2", grant_q[2].addr, 32'h308);
      check32("burst_addr3", grant_q[3].addr, 32'h30C);
      check32("burst_addr4", grant_q[4].addr, 32'h080);
      check32("burst_addr5", grant_q[5].addr, 32'h310);
      check32("burst_addr6", grant_q[6].addr, 32'h314);
    end

    // req held through its ack cycle: exactly one transaction
    grant_q.delete();
    a0 = if_acks;
    if_q.push_back(32'h0500_FAFF);
    bus.if_addr = 32'h0000_0500;
    bus.if_req  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.if_ack;
    end
    check1("hold_ack_seen", got, 1'b1);
    @(posedge clk);
    #1 bus.if_req = 1'b0;
    repeat (8) @(negedge clk);
    checkn("hold_ack_count", if_acks - a0, 1);
    checkn("hold_grant_count", grant_q.size(), 1);

    // timeout: memory never ready
    check1("pre_timeout_err", bus.err_timeout, 1'b0);
    mem_never = 1'b1;
    do_req(1'b1, 1'b0, 32'h0000_0600, 32'h0, MAX_WAIT + 2, 1'b0, 32'h0);
    check1("timeout_mem_req_dropped", bus.mem_req, 1'b0);
    check1("timeout_err_set", bus.err_timeout, 1'b1);
    mem_never = 1'b0;
    mem_lat   = 1;
    @(negedge clk);
    do_req(1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 1'b0, 32'h0040_FFBF);
    check1("timeout_err_sticky", bus.err_timeout, 1'b1);

    // asynchronous reset mid data access, 3-cycle memory
    @(negedge clk);
    mem_lat     = 3;
    a0          = dm_acks;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0700;
    bus.dm_req  = 1'b1;
    repeat (2) @(negedge clk);
    check1("inflight_mem_req", bus.mem_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check1 ("arst_mem_req",  bus.mem_req,     1'b0);
    check32("arst_mem_addr", bus.mem_addr,    32'h0);
    check1 ("arst_err",      bus.err_timeout, 1'b0);
    check32("arst_if_rdata", bus.if_rdata,    32'h0);
    check1 ("arst_dm_ack",   bus.dm_ack,      1'b0);
    bus.dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    checkn("arst_no_ack", dm_acks - a0, 0);
    mem_lat = 0;
    do_req(1'b0, 1'b0, 32'h0000_0044, 32'h0, 2, 1'b0, 32'h0044_FFBB);

    repeat (3) @(negedge clk);
    checkn("if_q_drained", if_q.size(), 0);
    checkn("dm_q_drained", dm_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
